gray_source_tx: RTL and testbench
=================================

Name: gray_source_tx

Overview:
- Sequential Gray-code source: the transmit-side counterpart of the Gray-input register/decoder/display path.
- Holds a binary count and advances it at a prescaled rate (free-run) or on a single-step request.
- Encodes the count to Gray and drives a registered WIDTH-bit Gray word, which feeds the Gray receiver's `Data_in`.
- Provides change and wrap strobes for the bench and for LEDs.

Parameters:
- WIDTH, 4, count and Gray word width.
- TICK_DIV, 25000000, clocks per free-run advance: 500 ms at 50 MHz. Minimum 2.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  reset, synchronous, active-high.
- run  in  1  level; 1 = free-run advance every TICK_DIV clocks.
- step  in  1  single-step request; acted on at rising edge only.
- dir  in  1  1 = count up, 0 = count down; sampled at each advance.
- load  in  1  load request; level, evaluated every clock.
- load_val  in  WIDTH  binary value to load.
- gray_out  out  WIDTH  registered Gray word, equal to bin ^ (bin >> 1).
- bin_out  out  WIDTH  registered binary count.
- tick  out  1  one-clock pulse in the cycle gray_out shows a newly advanced value.
- wrap  out  1  one-clock pulse coincident with tick when the advance wrapped.
- state_out  out  2  FSM state: 00 IDLE, 01 RUN, 10 STEP.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - bin_out=0, gray_out=0, tick=0, wrap=0, state=IDLE.
  - Prescaler=0, step edge register=0.
  - Reset overrides all inputs, including mid-run and mid-step.
- Gray encoding:
  - gray_out and bin_out are registered together and never disagree in any cycle.
  - Consecutive advances change exactly one gray_out bit, including at wrap.
- Advance:
  - bin <= bin+1 if dir=1, else bin-1, modulo 2^WIDTH.
  - tick=1 in the cycle the new value appears.
  - wrap=1 when up goes from all-ones to 0, or down goes from 0 to all-ones.
- Load (highest priority below rst):
  - bin_out <= load_val and gray_out <= encoded load_val on the next edge.
  - Prescaler cleared; tick=0, wrap=0.
  - A step edge in the same cycle is discarded.
  - State is unchanged.
- FSM:
  - IDLE:
    - run=1 -> RUN, prescaler starts at 0.
    - Else a step rising edge (step=1, step_d=0) -> STEP.
  - STEP:
    - Performs one advance on the next edge, then returns to IDLE.
    - Total latency: step rise to gray_out change = 2 clocks.
    - run is ignored during this one cycle.
  - RUN:
    - Prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it advances and resets to 0.
    - First advance occurs TICK_DIV clocks after entry.
    - step is ignored; its edge register still tracks step, so no stale edge fires later.
    - run=0 -> IDLE on the next edge, prescaler cleared, no advance in that cycle.
- Simultaneous events:
  - If run falls in the same cycle as the terminal count, no advance occurs (run=0 wins).
  - A dir change takes effect at the next advance only.
- Outputs tick and wrap are strobes; they are never high for two consecutive cycles unless TICK_DIV=... n/a, since the minimum spacing is 2.

Optional Feature:
- Macro: GRAY_PARITY_EN.
- Defined:
  - Adds output `parity` (1 bit): even parity (XOR reduction) of gray_out.
  - Registered in the same cycle as gray_out; reset value 0.
  - Parity toggles on every tick.
  - On load it equals the XOR of the encoded load_val.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (bench uses WIDTH=4, TICK_DIV=4):
- Reset: drive random inputs with rst=1 for 3 clks -> gray_out=0000, bin_out=0000, tick=0, wrap=0, state_out=00; with the macro defined, parity=0.
- Free-run up: run=1, dir=1 from 0 -> tick every 4 clks; gray_out follows 0000, 0001, 0011, 0010, 0110 ...; the 16th advance gives 1000 -> 0000 with wrap=1; every step changes exactly one bit.
- Step down from 0: step held high for 10 clks in IDLE with dir=0 -> exactly one advance, 2 clks after the rise; bin_out=1111, gray_out=1000, tick=1, wrap=1.
- Load while running: at bin=3, load=1 with load_val=1001 -> next clk gray_out=1101 with no tick; the next advance comes 4 clks later with bin=1010, gray=1111.
- run drop at terminal count: run=0 in the prescaler=3 cycle -> no advance, state_out=00, gray_out held.
- Mid-step reset: rst=1 in the STEP cycle -> no advance, all outputs 0, state IDLE.

Source files
------------

// File: rtl/gray_source_if.sv
// ============================================================================
// Module   : gray_source_if
// Purpose  : Control/data bundle between a Gray-code source and its user.
//            Carries the parity line only when GRAY_PARITY_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface gray_source_if #(
    parameter int WIDTH = 4
) ();
    logic             run;
    logic             step;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic             tick;
    logic             wrap;
    logic [1:0]       state_out;
`ifdef GRAY_PARITY_EN
    logic             parity;
`endif

    modport master (
        output run, step, dir, load, load_val,
        input  gray_out, bin_out, tick, wrap, state_out
`ifdef GRAY_PARITY_EN
        , input parity
`endif
    );

    modport slave (
        input  run, step, dir, load, load_val,
        output gray_out, bin_out, tick, wrap, state_out
`ifdef GRAY_PARITY_EN
        , output parity
`endif
    );
endinterface

`default_nettype wire

// File: rtl/gray_source_tx.sv
// ============================================================================
// Module   : gray_source_tx
// Purpose  : Binary counter advanced by prescaled free-run or single step,
//            driving a registered Gray word. Optional macro: GRAY_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gray_source_tx #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 25000000
) (
    input  logic          clk,
    input  logic          rst,
    gray_source_if.slave  bus
);

    localparam int             PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  TERM = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } state_t;

    state_t           state;
    logic [PW-1:0]    presc;
    logic             step_d;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] gray_word;
    logic             tick_pulse;
    logic             wrap_pulse;

    logic             step_rise;
    logic             terminal;
    logic             do_advance;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign step_rise  = bus.step & ~step_d;
    assign terminal   = (presc == TERM);
    assign next_count = bus.dir ? (count + 1'b1) : (count - 1'b1);
    assign next_wrap  = bus.dir ? (&count) : ~(|count);

    // A load pre-empts any advance due in the same cycle.
    assign do_advance = ~bus.load &
                        ((state == STEP) | ((state == RUN) & bus.run & terminal));

`ifdef GRAY_PARITY_EN
    logic parity_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            step_d     <= 1'b0;
            count      <= '0;
            gray_word  <= '0;
            tick_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
`ifdef GRAY_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            // The edge register follows step in every state so nothing stale fires later.
            step_d     <= bus.step;
            tick_pulse <= do_advance;
            wrap_pulse <= do_advance & next_wrap;

            if (do_advance) begin
                count     <= next_count;
                gray_word <= to_gray(next_count);
`ifdef GRAY_PARITY_EN
                parity_bit <= ^to_gray(next_count);
`endif
            end

            if (bus.load) begin
                count     <= bus.load_val;
                gray_word <= to_gray(bus.load_val);
                presc     <= '0;
`ifdef GRAY_PARITY_EN
                parity_bit <= ^to_gray(bus.load_val);
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.run) begin
                            state <= RUN;
                            presc <= '0;
                        end else if (step_rise) begin
                            state <= STEP;
                        end
                    end
                    STEP: begin
                        state <= IDLE;
                    end
                    RUN: begin
                        if (!bus.run) begin
                            state <= IDLE;
                            presc <= '0;
                        end else if (terminal) begin
                            presc <= '0;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        presc <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.gray_out  = gray_word;
    assign bus.bin_out   = count;
    assign bus.tick      = tick_pulse;
    assign bus.wrap      = wrap_pulse;
    assign bus.state_out = state;
`ifdef GRAY_PARITY_EN
    assign bus.parity    = parity_bit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_source_tx.sv
// ============================================================================
// Module   : tb_gray_source_tx
// Purpose  : Directed and randomized checks of gray_source_tx against a
//            behavioural model. Honours GRAY_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gray_source_tx;

    localparam int WIDTH    = 4;
    localparam int TICK_DIV = 4;
    localparam int MOD      = 1 << WIDTH;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_STEP   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_source_if #(.WIDTH(WIDTH)) bus ();

    gray_source_tx #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: count value, mode, clocks spent in RUN since last advance.
    int   m_bin  = 0;
    int   m_mode = M_IDLE;
    int   m_cnt  = 0;
    bit   m_prev_step = 1'b0;
    bit   m_tick = 1'b0;
    bit   m_wrap = 1'b0;
    int   m_gray_before = 0;
    bit   chk_en = 1'b0;
    logic [WIDTH-1:0] diff;

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_advance();
        int old;
        old           = m_bin;
        m_gray_before = gray_of(old);
        if (bus.dir) begin
            m_bin  = (old + 1) % MOD;
            m_wrap = (old == MOD - 1);
        end else begin
            m_bin  = (old + MOD - 1) % MOD;
            m_wrap = (old == 0);
        end
        m_tick = 1'b1;
    endtask

    task automatic model_step();
        bit rise;
        if (rst) begin
            m_bin = 0; m_mode = M_IDLE; m_cnt = 0;
            m_prev_step = 1'b0; m_tick = 1'b0; m_wrap = 1'b0;
        end else begin
            rise        = bus.step && !m_prev_step;
            m_prev_step = bus.step;
            m_tick      = 1'b0;
            m_wrap      = 1'b0;
            if (bus.load) begin
                m_bin = int'(bus.load_val);
                m_cnt = 0;
            end else if (m_mode == M_IDLE) begin
                if (bus.run) begin
                    m_mode = M_RUN;
                    m_cnt  = 0;
                end else if (rise) begin
                    m_mode = M_STEP;
                end
            end else if (m_mode == M_STEP) begin
                model_advance();
                m_mode = M_IDLE;
            end else begin
                if (!bus.run) begin
                    m_mode = M_IDLE;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == TICK_DIV) begin
                        model_advance();
                        m_cnt = 0;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("gray_out",  int'(bus.gray_out),  gray_of(m_bin));
            check("bin_out",   int'(bus.bin_out),   m_bin);
            check("tick",      int'(bus.tick),      int'(m_tick));
            check("wrap",      int'(bus.wrap),      int'(m_wrap));
            check("state_out", int'(bus.state_out), m_mode);
`ifdef GRAY_PARITY_EN
            check("parity", int'(bus.parity), $countones(gray_of(m_bin)) % 2);
`endif
            if (m_tick) begin
                diff = bus.gray_out ^ WIDTH'(m_gray_before);
                check("one_bit_change", $countones(diff), 1);
            end
        end
    end

    initial begin
        int exp_g[4];
        exp_g = '{1, 3, 2, 6};

        // Reset with random inputs.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.run      = 1'($urandom);
            bus.step     = 1'($urandom);
            bus.dir      = 1'($urandom);
            bus.load     = 1'($urandom);
            bus.load_val = WIDTH'($urandom);
            cyc();
            chk_en = 1'b1;
        end
        check("rst_gray",  int'(bus.gray_out), 0);
        check("rst_bin",   int'(bus.bin_out), 0);
        check("rst_tick",  int'(bus.tick), 0);
        check("rst_wrap",  int'(bus.wrap), 0);
        check("rst_state", int'(bus.state_out), 0);
`ifdef GRAY_PARITY_EN
        check("rst_parity", int'(bus.parity), 0);
`endif

        // Free-run up through a full wrap.
        rst = 1'b0; bus.run = 1'b1; bus.dir = 1'b1; bus.step = 1'b0;
        bus.load = 1'b0; bus.load_val = '0;
        cyc();
        check("fr_state", int'(bus.state_out), 1);
        for (int k = 1; k <= MOD; k++) begin
            repeat (TICK_DIV) cyc();
            check("fr_tick", int'(bus.tick), 1);
            if (k <= 4) check("fr_gray", int'(bus.gray_out), exp_g[k-1]);
            if (k == MOD - 1) check("fr_gray_15", int'(bus.gray_out), 8);
            if (k == MOD) begin
                check("fr_wrap_gray", int'(bus.gray_out), 0);
                check("fr_wrap", int'(bus.wrap), 1);
            end
        end

        // Leave RUN, then step down from 0 with step held high.
        bus.run = 1'b0;
        cyc();
        check("idle_state", int'(bus.state_out), 0);
        bus.dir = 1'b0; bus.step = 1'b1;
        cyc();
        check("step_state", int'(bus.state_out), 2);
        check("step_not_yet", int'(bus.bin_out), 0);
        cyc();
        check("step_bin",  int'(bus.bin_out), 15);
        check("step_gray", int'(bus.gray_out), 8);
        check("step_tick", int'(bus.tick), 1);
        check("step_wrap", int'(bus.wrap), 1);
        repeat (8) cyc();
        check("step_once", int'(bus.bin_out), 15);
        bus.step = 1'b0;
        cyc();

        // Load while running at bin=3.
        bus.load = 1'b1; bus.load_val = '0;
        cyc();
        bus.load = 1'b0; bus.run = 1'b1; bus.dir = 1'b1;
        cyc();
        repeat (3 * TICK_DIV) cyc();
        check("ld_pre_bin", int'(bus.bin_out), 3);
        bus.load = 1'b1; bus.load_val = 4'b1001;
        cyc();
        check("ld_gray", int'(bus.gray_out), 13);
        check("ld_tick", int'(bus.tick), 0);
        bus.load = 1'b0;
        repeat (TICK_DIV - 1) cyc();
        check("ld_hold", int'(bus.bin_out), 9);
        cyc();
        check("ld_adv_bin",  int'(bus.bin_out), 10);
        check("ld_adv_gray", int'(bus.gray_out), 15);
        check("ld_adv_tick", int'(bus.tick), 1);

        // run drops in the terminal-count cycle.
        repeat (TICK_DIV - 1) cyc();
        bus.run = 1'b0;
        cyc();
        check("drop_state", int'(bus.state_out), 0);
        check("drop_bin",   int'(bus.bin_out), 10);
        check("drop_tick",  int'(bus.tick), 0);

        // Reset during the STEP cycle.
        bus.step = 1'b1;
        cyc();
        check("ms_state", int'(bus.state_out), 2);
        rst = 1'b1;
        cyc();
        check("ms_bin",   int'(bus.bin_out), 0);
        check("ms_gray",  int'(bus.gray_out), 0);
        check("ms_tick",  int'(bus.tick), 0);
        check("ms_state", int'(bus.state_out), 0);
        rst = 1'b0; bus.step = 1'b0;
        cyc();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            bus.load     = ($urandom_range(0, 19) == 0);
            bus.load_val = WIDTH'($urandom);
            bus.dir      = 1'($urandom);
            bus.step     = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) bus.run = ~bus.run;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
